// File: rtl/ram_grain_pingpong_buf.sv
// Ping-pong byte-lane input buffer between the loader DMA and the PE array.
// Two pages of NUM_LANES banks; sub-word write modes and a lane-rotated half-step read.
module ram_grain_pingpong_buf #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 8,
  parameter int ADDR_W    = 6
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   wr_en,
  input  logic [1:0]                             wr_mode,
  input  logic [ADDR_W+$clog2(NUM_LANES)-1:0]    wr_addr,
  input  logic [NUM_LANES*LANE_W-1:0]            wr_data,
  input  logic                                   wr_page_done,
  output logic                                   wr_ready,
  input  logic                                   rd_en,
  input  logic                                   rd_kmode,
  input  logic [ADDR_W:0]                        rd_addr,
  input  logic                                   rd_release,
  output logic                                   rd_avail,
  output logic [NUM_LANES*LANE_W-1:0]            rd_data,
  output logic                                   rd_dvalid,
  output logic                                   wr_page,
  output logic                                   rd_page,
  output logic                                   err_ovf,
  output logic                                   err_udf,
  output logic                                   err_mode
);

  localparam int L  = NUM_LANES;
  localparam int H  = L / 2;
  localparam int LG = $clog2(L);
  localparam int W  = L * LANE_W;
  localparam int D  = 2 ** ADDR_W;

  // Storage is never reset; only control and the read register are.
  logic [LANE_W-1:0] r_mem [2][L][D];

  logic [1:0]        r_count;
  logic              r_wr_page;
  logic              r_rd_page;
  logic [W-1:0]      r_rd_data;
  logic              r_rd_dvalid;
  logic              r_err_ovf;
  logic              r_err_udf;
  logic              r_err_mode;

  logic              w_cnt_full;
  logic              w_cnt_empty;
  logic              w_done_ok;
  logic              w_rel_ok;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic [1:0]        w_count_nxt;

  logic [L-1:0]      w_lane_we;
  logic [ADDR_W-1:0] w_lane_waddr [L];
  logic [LANE_W-1:0] w_lane_wdata [L];

  logic              w_rd_half;
  logic [ADDR_W-1:0] w_rd_base;
  logic [ADDR_W-1:0] w_rd_next;
  logic [W-1:0]      w_rd_word;

  assign w_cnt_full  = (r_count == 2'd2);
  assign w_cnt_empty = (r_count == 2'd0);

  // A simultaneous done+release is resolved by the count: a full buffer only
  // frees, an empty one only fills, and count==1 swaps both pages.
  assign w_done_ok = wr_page_done & ~w_cnt_full;
  assign w_rel_ok  = rd_release & ~w_cnt_empty;
  assign w_wr_ok   = wr_en & ~w_cnt_full & (wr_mode != 2'd3);
  assign w_rd_ok   = rd_en & ~w_cnt_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_done_ok, w_rel_ok})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Per-lane write steering for the three write modes.
  for (genvar g = 0; g < L; g++) begin : g_wr_lane
    localparam logic HI_HALF = (g >= H) ? 1'b1 : 1'b0;

    assign w_lane_we[g] = (wr_mode == 2'd0)
                        | ((wr_mode == 2'd1) & (wr_addr[0] == HI_HALF))
                        | ((wr_mode == 2'd2) & (wr_addr[LG-1:0] == LG'(g)));

    assign w_lane_waddr[g] = (wr_mode == 2'd1) ? wr_addr[ADDR_W:1]
                           : (wr_mode == 2'd2) ? wr_addr[ADDR_W+LG-1:LG]
                           :                     wr_addr[ADDR_W-1:0];

    assign w_lane_wdata[g] = (wr_mode == 2'd1) ? wr_data[(g % H)*LANE_W +: LANE_W]
                           : (wr_mode == 2'd2) ? wr_data[LANE_W-1:0]
                           :                     wr_data[g*LANE_W +: LANE_W];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < L; i++) begin
      if (w_wr_ok && w_lane_we[i]) begin
        r_mem[r_wr_page][i][w_lane_waddr[i]] <= w_lane_wdata[i];
      end
    end
  end

  // Half-step read: upper banks of row p feed the low output lanes, lower
  // banks of row p+1 (wrapping at D) feed the high output lanes.
  assign w_rd_half = rd_kmode & rd_addr[0];
  assign w_rd_base = rd_kmode ? rd_addr[ADDR_W:1] : rd_addr[ADDR_W-1:0];
  assign w_rd_next = w_rd_base + ADDR_W'(1);

  for (genvar g = 0; g < L; g++) begin : g_rd_lane
    localparam int SRC = (g + H) % L;

    assign w_rd_word[g*LANE_W +: LANE_W] =
        !w_rd_half ? r_mem[r_rd_page][g][w_rd_base]
      : (g < H)    ? r_mem[r_rd_page][SRC][w_rd_base]
      :              r_mem[r_rd_page][SRC][w_rd_next];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= 2'd0;
      r_wr_page   <= 1'b0;
      r_rd_page   <= 1'b0;
      r_rd_data   <= '0;
      r_rd_dvalid <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_udf   <= 1'b0;
      r_err_mode  <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_wr_page   <= r_wr_page ^ w_done_ok;
      r_rd_page   <= r_rd_page ^ w_rel_ok;
      r_rd_dvalid <= w_rd_ok;
      if (w_rd_ok) begin
        r_rd_data <= w_rd_word;
      end
      r_err_ovf  <= r_err_ovf  | ((wr_en | wr_page_done) & w_cnt_full);
      r_err_udf  <= r_err_udf  | ((rd_en | rd_release) & w_cnt_empty);
      r_err_mode <= r_err_mode | (wr_en & (wr_mode == 2'd3));
    end
  end

  assign wr_ready  = ~w_cnt_full;
  assign rd_avail  = ~w_cnt_empty;
  assign rd_data   = r_rd_data;
  assign rd_dvalid = r_rd_dvalid;
  assign wr_page   = r_wr_page;
  assign rd_page   = r_rd_page;
  assign err_ovf   = r_err_ovf;
  assign err_udf   = r_err_udf;
  assign err_mode  = r_err_mode;

endmodule

// File: tb/tb_ram_grain_pingpong_buf.sv
// Table-driven bench for ram_grain_pingpong_buf with a read-data scoreboard
// (4 lanes x 8 bits, 64-entry banks).
module tb_ram_grain_pingpong_buf;

  localparam int L  = 4;
  localparam int LW = 8;
  localparam int AW = 6;
  localparam int LG = 2;
  localparam int W  = L * LW;

  localparam int OP_WR   = 0;
  localparam int OP_DONE = 1;
  localparam int OP_REL  = 2;
  localparam int OP_RD0  = 3;
  localparam int OP_RD1  = 4;
  localparam int OP_DR   = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_en;
  logic [1:0]     wr_mode;
  logic [AW+LG-1:0] wr_addr;
  logic [W-1:0]   wr_data;
  logic           wr_page_done;
  logic           wr_ready;
  logic           rd_en;
  logic           rd_kmode;
  logic [AW:0]    rd_addr;
  logic           rd_release;
  logic           rd_avail;
  logic [W-1:0]   rd_data;
  logic           rd_dvalid;
  logic           wr_page;
  logic           rd_page;
  logic           err_ovf;
  logic           err_udf;
  logic           err_mode;

  always #5 clk = ~clk;

  ram_grain_pingpong_buf #(
    .NUM_LANES(L),
    .LANE_W(LW),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_mode(wr_mode),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_page_done(wr_page_done),
    .wr_ready(wr_ready),
    .rd_en(rd_en),
    .rd_kmode(rd_kmode),
    .rd_addr(rd_addr),
    .rd_release(rd_release),
    .rd_avail(rd_avail),
    .rd_data(rd_data),
    .rd_dvalid(rd_dvalid),
    .wr_page(wr_page),
    .rd_page(rd_page),
    .err_ovf(err_ovf),
    .err_udf(err_udf),
    .err_mode(err_mode)
  );

  // st = {wr_page, rd_page, wr_ready, rd_avail} expected after the vector's edge.
  typedef struct {
    int          op;
    logic [1:0]  mode;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  st;
  } vec_t;

  vec_t        tv[$];
  logic [31:0] sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  function automatic void add(int op, logic [1:0] mode, logic [7:0] addr,
                              logic [31:0] data, logic [3:0] st);
    vec_t v;
    v.op = op; v.mode = mode; v.addr = addr; v.data = data; v.st = st;
    tv.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    wr_en = 1'b0; wr_mode = 2'd0; wr_addr = '0; wr_data = '0; wr_page_done = 1'b0;
    rd_en = 1'b0; rd_kmode = 1'b0; rd_addr = '0; rd_release = 1'b0;
  endtask

  task automatic tick();
    logic [31:0] exp_d;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      exp_d = sb_q.pop_front();
      check("rd_dvalid", {31'd0, rd_dvalid}, 32'd1);
      check("rd_data", rd_data, exp_d);
    end else begin
      check("rd_dvalid_idle", {31'd0, rd_dvalid}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {26'd0, wr_page, rd_page, wr_ready, rd_avail, rd_dvalid, err_ovf},
          32'b0_0_1_0_0_0);
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_err", {30'd0, err_udf, err_mode}, 32'd0);
    rst = 1'b0;

    // Read with nothing available: rejected, flagged.
    rd_en = 1'b1;
    tick();
    clear_inputs();
    check("udf_flag", {29'd0, err_udf, err_ovf, err_mode}, 32'b100);

    add(OP_WR,   2'd0, 8'd5,   32'h44332211, 4'b0010);
    add(OP_DONE, 2'd0, 8'd0,   32'h0,        4'b1011);
    add(OP_RD0,  2'd0, 8'd5,   32'h44332211, 4'b1011);
    add(OP_REL,  2'd0, 8'd0,   32'h0,        4'b1110);
    add(OP_WR,   2'd0, 8'd2,   32'hD4C3B2A1, 4'b1110);
    add(OP_WR,   2'd0, 8'd3,   32'h88776655, 4'b1110);
    add(OP_DONE, 2'd0, 8'd0,   32'h0,        4'b0111);
    add(OP_RD1,  2'd0, 8'd4,   32'hD4C3B2A1, 4'b0111);
    add(OP_RD1,  2'd0, 8'd5,   32'h6655D4C3, 4'b0111);
    add(OP_REL,  2'd0, 8'd0,   32'h0,        4'b0010);
    add(OP_WR,   2'd2, 8'd0,   32'h00000011, 4'b0010);
    add(OP_WR,   2'd2, 8'd1,   32'h00000022, 4'b0010);
    add(OP_WR,   2'd2, 8'd2,   32'h00000033, 4'b0010);
    add(OP_WR,   2'd2, 8'd3,   32'h00000044, 4'b0010);
    add(OP_WR,   2'd1, 8'd2,   32'h0000BBAA, 4'b0010);
    add(OP_WR,   2'd1, 8'd3,   32'h0000DDCC, 4'b0010);
    add(OP_DONE, 2'd0, 8'd0,   32'h0,        4'b1011);
    add(OP_RD0,  2'd0, 8'd0,   32'h44332211, 4'b1011);
    add(OP_RD0,  2'd0, 8'd1,   32'hDDCCBBAA, 4'b1011);
    add(OP_REL,  2'd0, 8'd0,   32'h0,        4'b1110);
    add(OP_WR,   2'd0, 8'd63,  32'hDDCCBBAA, 4'b1110);
    add(OP_WR,   2'd0, 8'd0,   32'h44332211, 4'b1110);
    add(OP_DONE, 2'd0, 8'd0,   32'h0,        4'b0111);
    add(OP_RD1,  2'd0, 8'd127, 32'h2211DDCC, 4'b0111);
    add(OP_REL,  2'd0, 8'd0,   32'h0,        4'b0010);
    add(OP_WR,   2'd3, 8'd0,   32'hFFFFFFFF, 4'b0010);
    add(OP_DONE, 2'd0, 8'd0,   32'h0,        4'b1011);
    add(OP_RD0,  2'd0, 8'd0,   32'h44332211, 4'b1011);
    add(OP_DONE, 2'd0, 8'd0,   32'h0,        4'b0001);
    add(OP_WR,   2'd0, 8'd0,   32'hDEADBEEF, 4'b0001);
    add(OP_RD0,  2'd0, 8'd0,   32'h44332211, 4'b0001);
    add(OP_REL,  2'd0, 8'd0,   32'h0,        4'b0111);
    add(OP_DR,   2'd0, 8'd0,   32'h0,        4'b1011);

    foreach (tv[i]) begin
      case (tv[i].op)
        OP_WR: begin
          wr_en = 1'b1; wr_mode = tv[i].mode; wr_addr = tv[i].addr; wr_data = tv[i].data;
        end
        OP_DONE: wr_page_done = 1'b1;
        OP_REL:  rd_release = 1'b1;
        OP_RD0, OP_RD1: begin
          rd_en = 1'b1;
          rd_kmode = (tv[i].op == OP_RD1);
          rd_addr = tv[i].addr[AW:0];
          sb_q.push_back(tv[i].data);
        end
        OP_DR: begin
          wr_page_done = 1'b1; rd_release = 1'b1;
        end
        default: ;
      endcase
      tick();
      clear_inputs();
      check($sformatf("state[%0d]", i), {28'd0, wr_page, rd_page, wr_ready, rd_avail},
            {28'd0, tv[i].st});
    end

    check("sticky_err", {29'd0, err_ovf, err_udf, err_mode}, 32'b111);

    // Accepted read, then reset right after the data register loads.
    rd_en = 1'b1; rd_kmode = 1'b0; rd_addr = '0;
    sb_q.push_back(32'h44332211);
    tick();
    clear_inputs();
    rst = 1'b1;
    #1;
    check("rst_dvalid", {31'd0, rd_dvalid}, 32'd0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_state", {26'd0, wr_page, rd_page, wr_ready, rd_avail, err_ovf, err_udf},
          32'b0_0_1_0_0_0);
    check("rst_err_mode", {31'd0, err_mode}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
